voxel_scan_reader: RTL and testbench
====================================

VOXEL_SCAN_READER -- requirements
Module: voxel_scan_reader

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 64, voxels per axis; only 64 is supported, matching voxel_memory_64.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a full-volume scan.
REQ-005 SHALL have port busy  output  1  high from the cycle after start is accepted until the done pulse.
REQ-006 SHALL have port done  output  1  one-cycle pulse at scan completion.
REQ-007 SHALL have port read_addr  output  18  voxel address {x,y,z} presented to the voxel_memory_64 read port.
REQ-008 SHALL have port read_en  output  1  read strobe, combinational from state and counters.
REQ-009 SHALL have port read_data  input  64  voxel word; valid in the cycle after read_en was high.
REQ-010 SHALL have port out_valid  output  1  occupied-voxel record available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the record.
REQ-012 SHALL have port out_addr  output  18  address of the emitted voxel.
REQ-013 SHALL have port out_data  output  64  voxel word of the emitted voxel.
REQ-014 SHALL have port occupied_count  output  19  number of occupied voxels found in the current or last scan.
REQ-015 SHALL have ports bbox_min and bbox_max  output  18 each  {x,y,z} per-axis minimum and maximum over occupied voxels.

Function
REQ-016 SHALL implement states S_IDLE, S_SCAN, S_DRAIN and S_FINISH.
REQ-017 S_IDLE: when start=1, SHALL clear x, y, z, occupied_count and bbox, set busy, and go to S_SCAN; start SHALL be ignored in every other state.
REQ-018 SHALL scan z fastest, then y, then x, with read_addr={x,y,z}.
REQ-019 S_SCAN: read_en SHALL be 1 iff fifo_count + rd_pending < 2, where rd_pending is read_en delayed by one cycle.
REQ-020 SHALL advance the counter only on cycles with read_en=1, and SHALL go to S_DRAIN after issuing address 18'h3FFFF.
REQ-021 A voxel SHALL be occupied iff read_data != 64'd0; data SHALL be captured one cycle after its read_en.
REQ-022 Each occupied voxel SHALL be pushed, with its address, into a 2-entry FIFO and SHALL increment occupied_count; empty voxels SHALL be discarded.
REQ-023 out_valid SHALL equal FIFO not-empty; a record SHALL pop when out_valid and out_ready are both 1.
REQ-024 out_addr and out_data SHALL hold steady while out_valid=1 and out_ready=0.
REQ-025 Push and pop in the same cycle SHALL both take effect; the FIFO SHALL never overflow, which REQ-019 guarantees.
REQ-026 S_DRAIN: SHALL go to S_FINISH when rd_pending=0 and the FIFO is empty.
REQ-027 S_FINISH: SHALL drive busy=0 and done=1 for one cycle, then go to S_IDLE.
REQ-028 occupied_count SHALL hold its value after done until the next accepted start.
REQ-029 With out_ready held at 1 and no occupied voxels, the module SHALL issue one read per cycle, and done SHALL occur no later than 262150 cycles after start.

Reset
REQ-030 When rst_n=0 at a clock edge, the module SHALL enter S_IDLE with busy=0, done=0, read_en=0, read_addr=0, out_valid=0, out_addr=0, out_data=0, occupied_count=0, bbox_min=0, bbox_max=0 and rd_pending=0, and SHALL flush the FIFO.
REQ-031 Reset asserted mid-scan SHALL abort the scan without producing a done pulse; returned read data SHALL be ignored.

Configuration
REQ-032 With macro VOXEL_SCAN_BBOX_EN defined, each occupied voxel SHALL update bbox_min and bbox_max per axis; at start, bbox_min SHALL initialise to 18'h3FFFF and bbox_max to 0.
REQ-033 Without VOXEL_SCAN_BBOX_EN, bbox_min and bbox_max SHALL be tied to 0 and no bbox logic SHALL be synthesised.

Verification
REQ-034 All-zero memory, start pulse, out_ready=1 -> no out_valid, occupied_count=0, exactly one done pulse within 262150 cycles.
REQ-035 Memory with only address 18'h14000 (x=20) = 64'hFFA0C88B5A2B30 -> exactly one record, out_addr=18'h14000, out_data matching that word, occupied_count=1.
REQ-036 Full 64x64 plane at x=20, out_ready toggling 1/0 each cycle -> 4096 records, addresses strictly ascending, none dropped or duplicated, occupied_count=4096.
REQ-037 Plane occupied, out_ready=0 for 1000 cycles -> out_valid stays 1 with the record stable, read_en is 0 once fifo_count + rd_pending reaches 2, then the scan resumes when out_ready=1.
REQ-038 rst_n=0 for one cycle at scan address 5000, then start -> no done pulse from the aborted scan; the new scan restarts at address 0 with occupied_count=0.
REQ-039 With VOXEL_SCAN_BBOX_EN defined, a sphere of radius 7 centred (38,32,28) -> bbox_min={31,25,21}, bbox_max={45,39,35}.

Source files
------------

// File: rtl/voxel_scan_reader.sv
// voxel_scan_reader: walks every voxel of a 64^3 volume in {x,y,z} order
// (z fastest), reads each word from voxel_memory_64 and streams the occupied
// (non-zero) voxels out through a 2-entry FIFO with valid/ready handshake.
// Optional feature: define VOXEL_SCAN_BBOX_EN to track the per-axis bounding
// box of the occupied voxels; otherwise bbox_min/bbox_max are tied to zero.
module voxel_scan_reader #(
  parameter int GRID_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [17:0] read_addr,
  output logic        read_en,
  input  logic [63:0] read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_addr,
  output logic [63:0] out_data,
  output logic [18:0] occupied_count,
  output logic [17:0] bbox_min,
  output logic [17:0] bbox_max
);

  localparam int AXIS_W = $clog2(GRID_SIZE);
  localparam int ADDR_W = 3 * AXIS_W;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_FINISH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] pend_addr;
  logic              rd_pending;
  logic              start_ok;

  logic [ADDR_W-1:0] fifo_addr [2];
  logic [63:0]       fifo_data [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_count;
  logic              push, pop;

  // A read returning non-zero data is an occupied voxel and enters the FIFO.
  assign push      = rd_pending && (read_data != '0);
  assign pop       = out_valid && out_ready;
  assign out_valid = (fifo_count != 2'd0);
  assign out_addr  = fifo_addr[rd_ptr];
  assign out_data  = fifo_data[rd_ptr];
  assign read_addr = addr_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control outputs; reads are throttled so that in-flight
  // reads plus buffered records never exceed the FIFO depth.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    read_en   = 1'b0;
    start_ok  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        busy    = 1'b1;
        read_en = (fifo_count + {1'b0, rd_pending}) < 2'd2;
        if (read_en && (addr_cnt == '1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!rd_pending && (fifo_count == 2'd0)) state_nxt = S_FINISH;
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scan address counter and tracking of the read currently in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_cnt   <= '0;
      pend_addr  <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= read_en;
      if (start_ok) begin
        addr_cnt <= '0;
      end else if (read_en) begin
        addr_cnt  <= addr_cnt + ADDR_W'(1);
        pend_addr <= addr_cnt;
      end
    end
  end

  // Two-entry output FIFO; simultaneous push and pop both take effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= pend_addr;
        fifo_data[wr_ptr] <= read_data;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Occupied-voxel counter; holds after done until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n)        occupied_count <= '0;
    else if (start_ok) occupied_count <= '0;
    else if (push)     occupied_count <= occupied_count + 19'd1;
  end

`ifdef VOXEL_SCAN_BBOX_EN
  // Per-axis running min/max over occupied voxel coordinates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bbox_min <= '0;
      bbox_max <= '0;
    end else if (start_ok) begin
      bbox_min <= '1;
      bbox_max <= '0;
    end else if (push) begin
      for (int unsigned a = 0; a < 3; a++) begin
        if (pend_addr[a*AXIS_W +: AXIS_W] < bbox_min[a*AXIS_W +: AXIS_W])
          bbox_min[a*AXIS_W +: AXIS_W] <= pend_addr[a*AXIS_W +: AXIS_W];
        if (pend_addr[a*AXIS_W +: AXIS_W] > bbox_max[a*AXIS_W +: AXIS_W])
          bbox_max[a*AXIS_W +: AXIS_W] <= pend_addr[a*AXIS_W +: AXIS_W];
      end
    end
  end
`else
  assign bbox_min = '0;
  assign bbox_max = '0;
`endif

endmodule

// File: tb/tb_voxel_scan_reader.sv
// Scoreboard bench for voxel_scan_reader: the stimulus process queues the
// expected records, a negedge monitor compares them as the DUT presents them.
// Define VOXEL_SCAN_BBOX_EN to also exercise the bounding-box feature.
module tb_voxel_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, read_en, out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] read_addr, out_addr, bbox_min, bbox_max;
  logic [63:0] read_data, out_data;
  logic [18:0] occupied_count;

  typedef struct packed {
    logic [17:0] addr;
    logic [63:0] data;
  } rec_t;

  rec_t exp_q[$];
  int   mode = 0;
  int   total = 0;
  int   passed = 0;
  int   done_count = 0;

  voxel_scan_reader #(.GRID_SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .read_addr(read_addr), .read_en(read_en), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .occupied_count(occupied_count),
    .bbox_min(bbox_min), .bbox_max(bbox_max)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [17:0] a);
    return 64'hA5A5_0000_0000_0000 | {46'd0, a};
  endfunction

  function automatic bit in_sphere(input logic [17:0] a);
    int dx, dy, dz;
    dx = int'(a[17:12]) - 38;
    dy = int'(a[11:6]) - 32;
    dz = int'(a[5:0]) - 28;
    return (dx*dx + dy*dy + dz*dz) <= 49;
  endfunction

  function automatic logic [63:0] mem_word(input logic [17:0] a, input int m);
    case (m)
      1:       return (a == 18'h14000) ? 64'hFFA0C88B5A2B30 : 64'd0;
      2:       return (a[17:12] == 6'd20) ? pat(a) : 64'd0;
      3:       return in_sphere(a) ? pat(a) : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  // Memory model: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk)
    read_data <= read_en ? mem_word(read_addr, mode) : 64'hDEAD_BEEF_0BAD_F00D;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Monitor: every presented record must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_count++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL extra_record: got addr %h data %h expected no record", out_addr, out_data);
        end else begin
          check("rec_addr", 64'(out_addr), 64'(exp_q[0].addr));
          check("rec_data", out_data, exp_q[0].data);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    bit ok;
    logic [17:0] a;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_read_en", 64'(read_en), 0);
    check("rst_read_addr", 64'(read_addr), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_addr", 64'(out_addr), 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", 64'(occupied_count), 0);
    check("rst_bbox_min", 64'(bbox_min), 0);
    check("rst_bbox_max", 64'(bbox_max), 0);
    rst_n = 1'b1;

    // Full plane at x=20, out_ready toggling, with a 1000-cycle stall
    mode = 2;
    for (int i = 0; i < 4096; i++) begin
      a = 18'h14000 + 18'(i);
      exp_q.push_back('{addr: a, data: pat(a)});
    end
    do_start();
    check("scan_first_addr", 64'(read_addr), 0);
    check("scan_busy", 64'(busy), 1);
    check("scan_read_en", 64'(read_en), 1);
    ok = 1'b0;
    for (int i = 0; i < 100000 && !ok; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      ok = (read_addr >= 18'h14100);
    end
    check("plane_reached", 64'(ok), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (i == 10 || i == 999) begin
        check("stall_read_en", 64'(read_en), 0);
        check("stall_out_valid", 64'(out_valid), 1);
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 60000 && !ok; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      ok = (read_addr >= 18'h15008) && (exp_q.size() == 0);
    end
    check("plane_drained", 64'(ok), 1);
    check("plane_count", 64'(occupied_count), 4096);
    out_ready = 1'b1;
    pulse_reset();
    check("abort_busy", 64'(busy), 0);
    check("abort_out_valid", 64'(out_valid), 0);
    check("abort_read_addr", 64'(read_addr), 0);
    check("abort_count", 64'(occupied_count), 0);

    // Empty volume: one read per cycle, reset at address 5000
    mode = 0;
    do_start();
    check("zero_first_addr", 64'(read_addr), 0);
    repeat (5000) @(posedge clk);
    #1;
    check("zero_addr_5000", 64'(read_addr), 5000);
    check("zero_read_en", 64'(read_en), 1);
    check("zero_count", 64'(occupied_count), 0);
    pulse_reset();
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_count), 0);
    check("abort2_busy", 64'(busy), 0);
    check("abort2_read_addr", 64'(read_addr), 0);

    // Single occupied voxel, full scan to done
    mode = 1;
    exp_q.push_back('{addr: 18'h14000, data: 64'hFFA0C88B5A2B30});
    do_start();
    check("single_first_addr", 64'(read_addr), 0);
    check("single_count_clr", 64'(occupied_count), 0);
    cyc = 0;
    ok = 1'b0;
    while (cyc < 262200 && !ok) begin
      @(posedge clk); #1;
      cyc++;
      ok = done;
    end
    check("done_seen", 64'(ok), 1);
    check("done_latency_ok", 64'(cyc <= 262150), 1);
    check("done_busy", 64'(busy), 0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 0);
    repeat (10) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_count), 1);
    check("single_count", 64'(occupied_count), 1);
    check("single_queue_empty", 64'(exp_q.size()), 0);
`ifdef VOXEL_SCAN_BBOX_EN
    check("single_bbox_min", 64'(bbox_min), 64'(18'h14000));
    check("single_bbox_max", 64'(bbox_max), 64'(18'h14000));

    // Sphere radius 7 centred (38,32,28)
    mode = 3;
    cyc = 0;
    for (int x = 31; x <= 45; x++)
      for (int y = 25; y <= 39; y++)
        for (int z = 21; z <= 35; z++) begin
          a = {x[5:0], y[5:0], z[5:0]};
          if (in_sphere(a)) begin
            exp_q.push_back('{addr: a, data: pat(a)});
            cyc++;
          end
        end
    do_start();
    ok = 1'b0;
    for (int i = 0; i < 262200 && !ok; i++) begin
      @(posedge clk); #1;
      ok = done;
    end
    check("sphere_done", 64'(ok), 1);
    check("sphere_count", 64'(occupied_count), 64'(cyc));
    check("sphere_bbox_min", 64'(bbox_min), 64'({6'd31, 6'd25, 6'd21}));
    check("sphere_bbox_max", 64'(bbox_max), 64'({6'd45, 6'd39, 6'd35}));
    check("sphere_queue_empty", 64'(exp_q.size()), 0);
`else
    check("bbox_min_tied", 64'(bbox_min), 0);
    check("bbox_max_tied", 64'(bbox_max), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
